// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD write controller: FSM states,
// command FIFO geometry, panel init sequence and status word layout.
package lcd_pkg;

    typedef enum logic [2:0] {
        PWRUP,
        INIT,
        IDLE,
        SETUP,
        PULSE,
        EXEC
    } state_t;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } cmd_t;

    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_W     = $bits(cmd_t);
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

    // Function set 8-bit/2-line, display on, clear, entry mode increment.
    localparam int INIT_LEN   = 4;
    localparam int INIT_SEL_W = $clog2(INIT_LEN);
    localparam int INIT_IDX_W = $clog2(INIT_LEN + 1);
    localparam logic [INIT_LEN-1:0][7:0] INIT_SEQ = {8'h06, 8'h01, 8'h0C, 8'h38};

    localparam int ST_BUSY    = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_CNT_LSB = 2;
    localparam int ST_OVF     = 5;

    // Clear and home are the only instructions that need the long execution wait.
    function automatic logic is_slow_cmd(cmd_t c);
        return !c.rs && (c.data == 8'h01 || c.data == 8'h02);
    endfunction

endpackage

// File: rtl/lcd_ctrl_if.sv
// Bundle of the CPU store/status path and the panel pins of the LCD controller.
interface lcd_ctrl_if;

    logic        wr;
    logic [31:0] wdata;
    logic [31:0] status;
    logic        lcd_on;
    logic        lcd_en;
    logic        lcd_rs;
    logic        lcd_rw;
    logic [7:0]  lcd_data;

    modport master (
        output wr, wdata,
        input  status, lcd_on, lcd_en, lcd_rs, lcd_rw, lcd_data
    );

    modport slave (
        input  wr, wdata,
        output status, lcd_on, lcd_en, lcd_rs, lcd_rw, lcd_data
    );

endinterface

// File: rtl/lcd_fifo.sv
// Small command FIFO; a pop in the same cycle frees the slot for a push to a full
// FIFO, and a refused push sets a sticky overflow flag.
module lcd_fifo
    import lcd_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [FIFO_W-1:0]     push_data,
    input  logic                  pop,
    output logic [FIFO_W-1:0]     head,
    output logic [FIFO_CNT_W-1:0] count,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [FIFO_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == FIFO_CNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
            if (push && !do_push) overflow <= 1'b1;
        end
    end

    // NOTE: storage has no reset; count/pointers guarantee stale entries are never read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/lcd_ctrl.sv
// LCD write controller: power-up delay, fixed init sequence, then replays queued
// {rs, byte} stores as SETUP / EN PULSE / EXEC wait cycles on the panel bus.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int POWERUP_CYC = 750000,
    parameter int SETUP_CYC   = 3,
    parameter int PULSE_CYC   = 12,
    parameter int EXEC_CYC    = 2500,
    parameter int CLR_CYC     = 82000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        wr_i,
    input  logic [31:0] wdata_i,
    output logic        lcd_on_o,
    output logic        lcd_en_o,
    output logic        lcd_rs_o,
    output logic        lcd_rw_o,
    output logic [7:0]  lcd_data_o,
    output logic [31:0] status_o
);

    localparam int MAX_CYC = (POWERUP_CYC > CLR_CYC) ? POWERUP_CYC : CLR_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic                    cnt_zero;
    cmd_t                    hold_q, hold_d, fifo_head, init_cmd;
    logic                    hold_load;
    logic [INIT_IDX_W-1:0]   init_idx_q, init_idx_d;
    logic                    fifo_pop, fifo_full, fifo_empty, fifo_ovf;
    logic [FIFO_CNT_W-1:0]   fifo_count;
    logic                    lcd_on_q;
    logic                    busy;
    logic                    unused_wdata;

    assign unused_wdata = ^wdata_i[30:9];

    lcd_fifo u_fifo (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .push      (wr_i),
        .push_data (wdata_i[8:0]),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .overflow  (fifo_ovf)
    );

    // Dwell length minus one for the state being entered; EXEC depends on the held command.
    function automatic logic [CNT_W-1:0] reload(state_t s, cmd_t c);
        case (s)
            PWRUP:   return CNT_W'(POWERUP_CYC - 1);
            SETUP:   return CNT_W'(SETUP_CYC - 1);
            PULSE:   return CNT_W'(PULSE_CYC - 1);
            EXEC:    return is_slow_cmd(c) ? CNT_W'(CLR_CYC - 1) : CNT_W'(EXEC_CYC - 1);
            default: return '0;
        endcase
    endfunction

    assign cnt_zero = (cnt_q == '0);
    assign init_cmd = cmd_t'{rs: 1'b0, data: INIT_SEQ[init_idx_q[INIT_SEL_W-1:0]]};

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= PWRUP;
            cnt_q   <= CNT_W'(POWERUP_CYC - 1);
        end else begin
            state_q <= state_d;
            if (state_d != state_q) cnt_q <= reload(state_d, hold_q);
            else if (!cnt_zero)     cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hold_q     <= '0;
            init_idx_q <= '0;
            lcd_on_q   <= 1'b0;
        end else begin
            if (hold_load) hold_q <= hold_d;
            init_idx_q <= init_idx_d;
            if (wr_i) lcd_on_q <= wdata_i[31];
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        hold_load  = 1'b0;
        hold_d     = fifo_head;
        fifo_pop   = 1'b0;
        init_idx_d = init_idx_q;
        case (state_q)
            PWRUP: if (cnt_zero) state_d = INIT;
            INIT: begin
                hold_load  = 1'b1;
                hold_d     = init_cmd;
                init_idx_d = init_idx_q + 1'b1;
                state_d    = SETUP;
            end
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    hold_load = 1'b1;
                    state_d   = SETUP;
                end
            end
            SETUP: if (cnt_zero) state_d = PULSE;
            PULSE: if (cnt_zero) state_d = EXEC;
            EXEC: begin
                if (cnt_zero) begin
                    // Init bytes take priority; queued stores wait until the sequence is done.
                    if (init_idx_q != INIT_IDX_W'(INIT_LEN)) begin
                        hold_load  = 1'b1;
                        hold_d     = init_cmd;
                        init_idx_d = init_idx_q + 1'b1;
                        state_d    = SETUP;
                    end else if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        hold_load = 1'b1;
                        state_d   = SETUP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = PWRUP;
        endcase
    end

    assign busy       = !(state_q == IDLE && fifo_empty);
    assign lcd_on_o   = lcd_on_q;
    assign lcd_en_o   = (state_q == PULSE);
    assign lcd_rs_o   = hold_q.rs;
    assign lcd_rw_o   = 1'b0;
    assign lcd_data_o = hold_q.data;

    always_comb begin
        status_o                                = '0;
        status_o[ST_BUSY]                       = busy;
        status_o[ST_FULL]                       = fifo_full;
        status_o[ST_CNT_LSB +: FIFO_CNT_W]      = fifo_count;
        status_o[ST_OVF]                        = fifo_ovf;
    end

endmodule
